// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit that sits beside the ALU in the execute
// stage and owns the architectural HI/LO registers.
//
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both retire
// one bit per cycle on operand magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly, but only while
// the unit is idle.
//
// Ports:
//   i_clk       system clock, all state changes on the rising edge
//   i_reset     synchronous active-high reset
//   i_start     launch an operation (sampled only when idle)
//   i_op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_in1       rs data: multiplicand or dividend
//   i_in2       rt data: multiplier or divisor
//   i_hi_write  MTHI strobe: hi <= i_wdata
//   i_lo_write  MTLO strobe: lo <= i_wdata
//   i_wdata     rs data for MTHI/MTLO
//   o_busy      operation in progress, issue must stall
//   o_done      one-cycle pulse: HI/LO now hold the new result
//   o_hi        HI register (product upper half or remainder)
//   o_lo        LO register (product lower half or quotient)
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic             i_hi_write,
    input  logic             i_lo_write,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);

    state_t r_state;
    state_t w_nextState;

    logic [CNT_W-1:0] r_cnt;
    logic             r_isDiv;
    logic             r_negRes;
    logic             r_negRem;
    logic             r_divZero;
    logic [WIDTH-1:0] r_orig1;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hiAcc;
    logic [WIDTH-1:0] r_loAcc;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    // Operand sign/magnitude decode. Negating 0x80000000 gives the same bit
    // pattern back, which read as unsigned is exactly 2^31.
    logic             w_isSigned;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    assign w_isSigned = ~i_op[0];
    assign w_neg1     = w_isSigned & i_in1[WIDTH-1];
    assign w_neg2     = w_isSigned & i_in2[WIDTH-1];
    assign w_mag1     = w_neg1 ? (~i_in1 + ONE_W) : i_in1;
    assign w_mag2     = w_neg2 ? (~i_in2 + ONE_W) : i_in2;

    // Multiply step. hiAcc holds the running upper half and loAcc holds the
    // remaining multiplier bits. The carry out of the add is shifted in so
    // that no bit of the product is lost.
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_mulSel;
    logic [WIDTH-1:0] w_mulHiNext;
    logic [WIDTH-1:0] w_mulLoNext;

    assign w_mulSum    = {1'b0, r_hiAcc} + {1'b0, r_opnd};
    assign w_mulSel    = r_loAcc[0] ? w_mulSum : {1'b0, r_hiAcc};
    assign w_mulHiNext = w_mulSel[WIDTH:1];
    assign w_mulLoNext = {w_mulSel[0], r_loAcc[WIDTH-1:1]};

    // Restoring divide step. hiAcc is the partial remainder and loAcc shifts
    // the dividend out while the quotient shifts in. When the trial
    // subtraction succeeds, the difference always fits in WIDTH bits, so a
    // WIDTH-bit subtract is enough.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_divHiNext;
    logic [WIDTH-1:0] w_divLoNext;

    assign w_shifted   = {r_hiAcc, r_loAcc[WIDTH-1]};
    assign w_diff      = w_shifted[WIDTH-1:0] - r_opnd;
    assign w_ge        = (w_shifted >= {1'b0, r_opnd});
    assign w_divHiNext = w_ge ? w_diff : w_shifted[WIDTH-1:0];
    assign w_divLoNext = {r_loAcc[WIDTH-2:0], w_ge};

    // Sign correction for the FIX cycle. Division by zero bypasses the
    // magnitude path and returns all-ones plus the untouched dividend.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_resHi;
    logic [WIDTH-1:0]   w_resLo;

    assign w_prod    = {r_hiAcc, r_loAcc};
    assign w_prodFix = r_negRes ? (~w_prod + ONE_2W) : w_prod;

    always_comb begin
        w_resHi = w_prodFix[2*WIDTH-1:WIDTH];
        w_resLo = w_prodFix[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_divZero) begin
                w_resHi = r_orig1;
                w_resLo = '1;
            end else begin
                w_resHi = r_negRem ? (~r_hiAcc + ONE_W) : r_hiAcc;
                w_resLo = r_negRes ? (~r_loAcc + ONE_W) : r_loAcc;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN lasts exactly WIDTH edges, counted by r_cnt.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_nextState = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_nextState = S_FIX;
            S_FIX:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath and HI/LO. Starting an operation takes priority over
    // MTHI/MTLO in the same cycle. While busy, HI/LO change only in FIX.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_orig1   <= '0;
            r_opnd    <= '0;
            r_hiAcc   <= '0;
            r_loAcc   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt     <= '0;
                        r_isDiv   <= i_op[1];
                        r_negRes  <= w_neg1 ^ w_neg2;
                        r_negRem  <= w_neg1;
                        r_divZero <= (i_in2 == '0);
                        r_orig1   <= i_in1;
                        r_hiAcc   <= '0;
                        if (i_op[1]) begin
                            r_opnd  <= w_mag2;
                            r_loAcc <= w_mag1;
                        end else begin
                            r_opnd  <= w_mag1;
                            r_loAcc <= w_mag2;
                        end
                    end else begin
                        if (i_hi_write) r_hi <= i_wdata;
                        if (i_lo_write) r_lo <= i_wdata;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_isDiv) begin
                        r_hiAcc <= w_divHiNext;
                        r_loAcc <= w_divLoNext;
                    end else begin
                        r_hiAcc <= w_mulHiNext;
                        r_loAcc <= w_mulLoNext;
                    end
                end
                S_FIX: begin
                    r_hi   <= w_resHi;
                    r_lo   <= w_resLo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Bench for mult_div_unit. It runs directed cases and randomized cases and
// compares every result against a reference model written with plain 64-bit
// arithmetic. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_op       (op),
        .i_in1      (in1),
        .i_in2      (in2),
        .i_hi_write (hiWrite),
        .i_lo_write (loWrite),
        .i_wdata    (wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. Every check is counted here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model with architectural semantics. Signed results come from
    // 64-bit signed arithmetic, which truncates toward zero. That arithmetic
    // also covers 0x80000000 / -1 without overflow.
    function automatic void modelOp(input logic [1:0] mop, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] rHi, output logic [31:0] rLo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rHi = '0;
        rLo = '0;
        case (mop)
            2'd0: begin
                p = sa * sb;
                rHi = p[63:32];
                rLo = p[31:0];
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                rHi = p[63:32];
                rLo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rHi = a;
                    rLo = 32'hFFFF_FFFF;
                end else if (mop == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    rHi = r[31:0];
                    rLo = q[31:0];
                end else begin
                    rHi = a % b;
                    rLo = a / b;
                end
            end
        endcase
    endfunction

    // Launches one operation at the current falling edge and follows it to
    // its done pulse. The task checks the latency, busy, that HI/LO hold
    // while busy, and the final HI/LO. Optionally it injects an ignored start
    // plus MTHI mid-run, or a same-cycle MTLO alongside the start.
    task automatic applyStimulus(input logic [1:0] sop, input logic [31:0] a,
                                 input logic [31:0] b, input int interfereAt,
                                 input logic withLoWrite);
        logic [31:0] mHi;
        logic [31:0] mLo;
        int          cyc;
        bit          seen;
        bit          busyBad;
        bit          holdBad;
        modelOp(sop, a, b, mHi, mLo);
        start   = 1'b1;
        op      = sop;
        in1     = a;
        in2     = b;
        loWrite = withLoWrite;
        wdata   = ~mLo;
        cyc     = 0;
        seen    = 1'b0;
        busyBad = 1'b0;
        holdBad = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start   = 1'b0;
                loWrite = 1'b0;
                op      = 2'($urandom);
                in1     = $urandom;
                in2     = $urandom;
            end
            if (interfereAt > 0 && cyc == interfereAt + 1) begin
                start   = 1'b0;
                hiWrite = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busyBad = 1'b1;
                if (hi !== expHi || lo !== expLo) holdBad = 1'b1;
            end
            if (interfereAt > 0 && cyc == interfereAt) begin
                start   = 1'b1;
                op      = 2'd3;
                in1     = 32'd9;
                in2     = 32'd3;
                hiWrite = 1'b1;
                wdata   = 32'hDEAD_BEEF;
            end
        end
        checkOutput("latency", 64'(cyc), 64'd34);
        checkOutput("busyWhileRunning", {63'd0, busyBad}, 64'd0);
        checkOutput("holdWhileBusy", {63'd0, holdBad}, 64'd0);
        checkOutput("busyAtDone", {63'd0, busy}, 64'd0);
        checkOutput("resultHi", {32'd0, hi}, {32'd0, mHi});
        checkOutput("resultLo", {32'd0, lo}, {32'd0, mLo});
        expHi = mHi;
        expLo = mLo;
    endtask

    // Watches a few idle cycles and expects no busy and no done.
    task automatic checkQuiet(input string tag, input int n);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        checkOutput(tag, {63'd0, bad}, 64'd0);
    endtask

    // Direct MTHI/MTLO write while idle. It must never pulse done.
    task automatic idleWrite(input logic hw, input logic lw, input logic [31:0] d);
        hiWrite = hw;
        loWrite = lw;
        wdata   = d;
        @(negedge clk);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        if (hw) expHi = d;
        if (lw) expLo = d;
        checkOutput("mtHi", {32'd0, hi}, {32'd0, expHi});
        checkOutput("mtLo", {32'd0, lo}, {32'd0, expLo});
        checkOutput("mtNoDone", {63'd0, done}, 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h0000_0001;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Main sequence. It covers reset, the directed cases, interference,
    // MTHI/MTLO, abort by reset, and then randomized back-to-back operations.
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        in1     = '0;
        in2     = '0;
        hiWrite = 1'b0;
        loWrite = 1'b0;
        wdata   = '0;
        expHi   = '0;
        expLo   = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", {63'd0, busy}, 64'd0);
        checkOutput("resetDone", {63'd0, done}, 64'd0);
        checkOutput("resetHi", {32'd0, hi}, 64'd0);
        checkOutput("resetLo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        checkOutput("planMultuHi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        checkOutput("planMultuLo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        checkQuiet("singleDonePulse", 2);

        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        checkOutput("planDivLo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        applyStimulus(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        applyStimulus(2'd3, 32'h1234_5678, 32'd0, 0, 1'b0);
        checkOutput("divZeroHi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        applyStimulus(2'd2, 32'hF000_0001, 32'd0, 0, 1'b0);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        checkOutput("overflowLo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        checkQuiet("quietAfterOps", 2);

        applyStimulus(2'd1, 32'd3, 32'd5, 10, 1'b0);
        checkOutput("interfereLo", {32'd0, lo}, 64'd15);
        checkQuiet("noSecondDone", 40);

        idleWrite(1'b1, 1'b1, 32'hA5A5_A5A5);
        idleWrite(1'b0, 1'b1, 32'h0F0F_0F0F);
        applyStimulus(2'd1, 32'd6, 32'd7, 0, 1'b1);
        checkQuiet("quietAfterStartWrite", 2);

        start = 1'b1;
        op    = 2'd0;
        in1   = 32'd2;
        in2   = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expHi = '0;
        expLo = '0;
        checkOutput("abortBusy", {63'd0, busy}, 64'd0);
        checkOutput("abortHi", {32'd0, hi}, 64'd0);
        checkOutput("abortLo", {32'd0, lo}, 64'd0);
        checkQuiet("abortNoDone", 25);
        applyStimulus(2'd0, 32'd2, 32'd2, 0, 1'b0);
        checkOutput("afterAbortLo", {32'd0, lo}, 64'd4);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 0, 1'b0);
            if (i % 6 == 5) begin
                idleWrite(1'($urandom), 1'($urandom), $urandom);
            end
        end
        checkQuiet("finalQuiet", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the execute path.
- Consumes the same register-file operands as the ALU (rs, rt data) and produces the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Multi-cycle: busy stalls the IFU/control; HI/LO feed the register write-data mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch an operation this cycle (sampled only when idle).
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- in1  input  WIDTH  rs data: multiplicand or dividend.
- in2  input  WIDTH  rt data: multiplier or divisor.
- hi_write  input  1  MTHI: hi <= wdata.
- lo_write  input  1  MTLO: lo <= wdata.
- wdata  input  WIDTH  rs data for MTHI/MTLO.
- busy  output  1  operation in progress; control must stall issue.
- done  output  1  one-cycle pulse: hi/lo now hold the new result.
- hi  output  WIDTH  HI register (product upper half or remainder).
- lo  output  WIDTH  LO register (product lower half or quotient).

Behaviour:
- Reset (sync, highest priority): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared. Reset during RUN/FIX aborts the operation and never updates hi/lo with partial data.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state. done is registered.
- IDLE:
  - start=1 latches op, operand magnitudes and result sign flags, clears the counter, and moves to RUN.
    - Signed ops (MULT, DIV) use absolute values.
    - |0x80000000| is treated as unsigned 2^31.
  - Otherwise hi_write/lo_write update hi/lo at the edge. Both may be asserted together.
  - start together with hi_write/lo_write in the same cycle: start wins; the writes are dropped.
- RUN: exactly 32 edges (counter 0..31). Counter wraps 31->0 on the RUN->FIX transition.
  - Multiply: shift-add, 1 bit/cycle, 64-bit unsigned product.
  - Divide: restoring, 1 quotient bit/cycle, unsigned quotient/remainder.
- FIX: one edge.
  - Applies sign correction:
    - Product negated if the operand signs differ.
    - Quotient negated if the operand signs differ.
    - Remainder takes the dividend's sign (truncate toward zero).
  - Writes hi/lo, sets done=1 for the next cycle, and returns to IDLE.
- Latency: start sampled at edge E0; busy=1 from after E0 through the cycle before E33. hi/lo update and done=1 in the cycle after E33; busy=0 in that same cycle.
- Back-to-back: start may be asserted in the done cycle; it is accepted (state is IDLE).
- While busy:
  - start is ignored (no queueing).
  - hi_write/lo_write are ignored.
  - hi/lo hold their previous values until FIX.
- Divide by zero (either sign): lo=0xFFFFFFFF, hi=in1 (original dividend, unmodified). Same 34-edge latency.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This is the natural result of the magnitude path; no trap.
- Operands are captured at E0. Changes on in1/in2/op after E0 have no effect.
- done is never asserted without a preceding accepted start. MTHI/MTLO never pulse done.

Test Plan:
- reset=1 for 2 cycles, then MULTU in1=0xFFFFFFFF in2=0xFFFFFFFF, start 1 cycle -> busy=1 for 33 cycles, then done=1 for 1 cycle with hi=0xFFFFFFFE lo=0x00000001; busy=0 in the done cycle.
- MULT in1=0xFFFFFFFD(-3) in2=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV in1=0xFFFFFFF9(-7) in2=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. Then DIVU same operands -> lo=0x7FFFFFFC hi=0x00000001.
- DIVU in1=0x12345678 in2=0 -> lo=0xFFFFFFFF hi=0x12345678 after 34 edges. DIV in1=0x80000000 in2=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Start MULTU 3*5; at cycle 10 assert start (DIVU 9/3) and hi_write with wdata=0xDEADBEEF -> both ignored; result hi=0 lo=15 at edge 33, exactly one done pulse.
- Idle: hi_write=1 lo_write=1 wdata=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5 next cycle, done stays 0. start+lo_write in same cycle -> operation runs; lo not written by wdata.
- Start MULT 2*2; assert reset at RUN cycle 15 -> next cycle state IDLE, busy=0, hi=lo=0, no done pulse. New start after reset completes normally (lo=4).
